// File: rtl/clock_cal_pkg.sv
// rtl/clock_cal_pkg.sv - shared BCD widths, month codes, day lengths and BCD step helpers for the calendar chain
package clock_cal_pkg;

  localparam int ONES_W  = 4;
  localparam int DTENS_W = 2;
  localparam int MTENS_W = 2;

  typedef logic [DTENS_W+ONES_W-1:0] bcd6_t;

  // {tens, ones} packed BCD, so the hex literal reads as the decimal value
  localparam bcd6_t MON_JAN = 6'h01;
  localparam bcd6_t MON_FEB = 6'h02;
  localparam bcd6_t MON_MAR = 6'h03;
  localparam bcd6_t MON_APR = 6'h04;
  localparam bcd6_t MON_MAY = 6'h05;
  localparam bcd6_t MON_JUN = 6'h06;
  localparam bcd6_t MON_JUL = 6'h07;
  localparam bcd6_t MON_AUG = 6'h08;
  localparam bcd6_t MON_SEP = 6'h09;
  localparam bcd6_t MON_OCT = 6'h10;
  localparam bcd6_t MON_NOV = 6'h11;
  localparam bcd6_t MON_DEC = 6'h12;

  localparam bcd6_t DAY_01  = 6'h01;
  localparam bcd6_t DAYS_28 = 6'h28;
  localparam bcd6_t DAYS_29 = 6'h29;
  localparam bcd6_t DAYS_30 = 6'h30;
  localparam bcd6_t DAYS_31 = 6'h31;

  function automatic bcd6_t bcd_inc(input bcd6_t v);
    if (v[ONES_W-1:0] == 4'd9)
      return {v[5:4] + 2'd1, 4'd0};
    else
      return {v[5:4], v[ONES_W-1:0] + 4'd1};
  endfunction

  function automatic bcd6_t bcd_dec(input bcd6_t v);
    if (v[ONES_W-1:0] == 4'd0)
      return {v[5:4] - 2'd1, 4'd9};
    else
      return {v[5:4], v[ONES_W-1:0] - 4'd1};
  endfunction

endpackage

// File: rtl/day_counter_if.sv
// rtl/day_counter_if.sv - day stage control/month/day signal bundle; leap_year exists only with DAY_COUNTER_LEAP_YEAR_EN
interface day_counter_if;
  import clock_cal_pkg::*;

  logic               day_en;
  logic               set_mode;
  logic               incr;
  logic               dcr;
  logic [MTENS_W-1:0] month_tens;
  logic [ONES_W-1:0]  month_ones;
`ifdef DAY_COUNTER_LEAP_YEAR_EN
  logic               leap_year;
`endif
  logic [DTENS_W-1:0] day_tens;
  logic [ONES_W-1:0]  day_ones;
  logic               month_en;

`ifdef DAY_COUNTER_LEAP_YEAR_EN
  modport master (output day_en, set_mode, incr, dcr, month_tens, month_ones, leap_year,
                  input  day_tens, day_ones, month_en);
  modport slave  (input  day_en, set_mode, incr, dcr, month_tens, month_ones, leap_year,
                  output day_tens, day_ones, month_en);
`else
  modport master (output day_en, set_mode, incr, dcr, month_tens, month_ones,
                  input  day_tens, day_ones, month_en);
  modport slave  (input  day_en, set_mode, incr, dcr, month_tens, month_ones,
                  output day_tens, day_ones, month_en);
`endif

endinterface

// File: rtl/days_in_month.sv
// rtl/days_in_month.sv - combinational BCD month (+leap) to BCD month length; illegal month codes give 31
module days_in_month
  import clock_cal_pkg::*;
(
  input  logic [MTENS_W-1:0] i_month_tens,
  input  logic [ONES_W-1:0]  i_month_ones,
  input  logic               i_leap_year,
  output bcd6_t              o_max_day
);

  always_comb begin
    o_max_day = DAYS_31;
    case ({i_month_tens, i_month_ones})
      MON_FEB:                            o_max_day = i_leap_year ? DAYS_29 : DAYS_28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: o_max_day = DAYS_30;
      default:                            o_max_day = DAYS_31;
    endcase
  end

endmodule

// File: rtl/day_counter.sv
// rtl/day_counter.sv - BCD day-of-month counter with month carry and manual set; DAY_COUNTER_LEAP_YEAR_EN enables leap February
module day_counter
  import clock_cal_pkg::*;
#(
  parameter int RESET_DAY = 1
)
(
  input  logic          clk,
  input  logic          rst_n,
  day_counter_if.slave  bus
);

  localparam bcd6_t RESET_BCD = {2'(RESET_DAY / 10), 4'(RESET_DAY % 10)};

  bcd6_t r_day;
  logic  r_month_en;
  bcd6_t w_max_day;
  logic  w_leap;
  logic  w_clamp;

`ifdef DAY_COUNTER_LEAP_YEAR_EN
  assign w_leap = bus.leap_year;
`else
  assign w_leap = 1'b0;
`endif

  days_in_month u_days_in_month (
    .i_month_tens (bus.month_tens),
    .i_month_ones (bus.month_ones),
    .i_leap_year  (w_leap),
    .o_max_day    (w_max_day)
  );

  // Packed BCD orders like binary, so a plain compare detects an over-long day
  assign w_clamp = (r_day > w_max_day);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_day      <= RESET_BCD;
      r_month_en <= 1'b0;
    end else begin
      r_month_en <= 1'b0;
      if (w_clamp) begin
        r_day <= w_max_day;
      end else if (!bus.set_mode) begin
        if (bus.day_en) begin
          if (r_day == w_max_day) begin
            r_day      <= DAY_01;
            r_month_en <= 1'b1;
          end else begin
            r_day <= bcd_inc(r_day);
          end
        end
      end else if (bus.incr && !bus.dcr) begin
        r_day <= (r_day == w_max_day) ? DAY_01 : bcd_inc(r_day);
      end else if (bus.dcr && !bus.incr) begin
        r_day <= (r_day == DAY_01) ? w_max_day : bcd_dec(r_day);
      end
    end
  end

  assign bus.day_tens = r_day[5:4];
  assign bus.day_ones = r_day[ONES_W-1:0];
  assign bus.month_en = r_month_en;

endmodule

// File: tb/tb_day_counter.sv
// tb/tb_day_counter.sv - directed and randomized check of day_counter against a decimal calendar model
module tb_day_counter;

  localparam int RST_DAY = 1;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  int   m_day;
  int   m_men;

  day_counter_if u_if ();

  day_counter #(.RESET_DAY(RST_DAY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_max();
    int len [13] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int num;
    int lp;
    lp = 0;
`ifdef DAY_COUNTER_LEAP_YEAR_EN
    lp = int'(u_if.leap_year);
`endif
    num = int'(u_if.month_tens) * 10 + int'(u_if.month_ones);
    if (u_if.month_ones > 4'd9 || num < 1 || num > 12) return 31;
    if (num == 2 && lp == 1) return 29;
    return len[num];
  endfunction

  task automatic check_out(input string tag);
    chk({tag, ".tens"}, int'(u_if.day_tens), m_day / 10);
    chk({tag, ".ones"}, int'(u_if.day_ones), m_day % 10);
    chk({tag, ".men"},  int'(u_if.month_en), m_men);
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are compared
  task automatic cyc(input string tag);
    int mx;
    @(posedge clk);
    mx    = ref_max();
    m_men = 0;
    if (m_day > mx) begin
      m_day = mx;
    end else if (!u_if.set_mode) begin
      if (u_if.day_en) begin
        if (m_day == mx) begin
          m_day = 1;
          m_men = 1;
        end else begin
          m_day = m_day + 1;
        end
      end
    end else if (u_if.incr && !u_if.dcr) begin
      m_day = (m_day == mx) ? 1 : m_day + 1;
    end else if (u_if.dcr && !u_if.incr) begin
      m_day = (m_day == 1) ? mx : m_day - 1;
    end
    #1;
    check_out(tag);
  endtask

  task automatic set_month(input int num);
    u_if.month_tens = 2'(num / 10);
    u_if.month_ones = 4'(num % 10);
  endtask

  task automatic advance_to(input int d, input string tag);
    int guard;
    guard = 0;
    u_if.set_mode = 1'b0;
    u_if.day_en   = 1'b1;
    while (m_day != d && guard < 64) begin
      cyc(tag);
      guard++;
    end
    chk({tag, ".reach"}, m_day, d);
    u_if.day_en = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    u_if.day_en   = 1'b0;
    u_if.set_mode = 1'b0;
    u_if.incr     = 1'b0;
    u_if.dcr      = 1'b0;
`ifdef DAY_COUNTER_LEAP_YEAR_EN
    u_if.leap_year = 1'b0;
`endif
    set_month(1);
    m_day = RST_DAY;
    m_men = 0;
    #12;
    check_out("reset");
    rst_n = 1'b1;

    // January: 01 -> 31, then rollover with carry
    advance_to(31, "jan");
    u_if.day_en = 1'b1;
    cyc("jan_roll");
    chk("jan_roll_pulse", int'(u_if.month_en), 1);

    // Async reset in the middle of the carry pulse
    #2 rst_n = 1'b0;
    #1;
    m_day = RST_DAY;
    m_men = 0;
    check_out("async_rst");
    #2 rst_n = 1'b1;
    u_if.day_en = 1'b0;
    cyc("post_rst_idle");
    u_if.day_en = 1'b1;
    cyc("post_rst_count");

    // April: 29 -> 30 without carry, 30 -> 01 with carry
    set_month(4);
    advance_to(29, "apr");
    u_if.day_en = 1'b1;
    cyc("apr_30");
    cyc("apr_roll");
    u_if.day_en = 1'b0;
    cyc("apr_idle");

    // Set mode in June
    set_month(6);
    u_if.set_mode = 1'b1;
    u_if.dcr = 1'b1;
    cyc("set_dcr_wrap");
    u_if.dcr = 1'b0; u_if.incr = 1'b1;
    cyc("set_incr_wrap");
    u_if.dcr = 1'b1;
    cyc("set_both");
    u_if.incr = 1'b0; u_if.dcr = 1'b0; u_if.day_en = 1'b1;
    cyc("set_day_en");
    u_if.dcr = 1'b1; u_if.day_en = 1'b0;
    cyc("set_dcr_step");
    u_if.dcr = 1'b0;
    u_if.set_mode = 1'b0;

    // Month switch 01 -> 11 at day 31 clamps and drops day_en
    set_month(1);
    advance_to(31, "clamp_prep");
    set_month(11);
    u_if.day_en = 1'b1;
    cyc("clamp");
    u_if.day_en = 1'b0;
    cyc("clamp_hold");

`ifdef DAY_COUNTER_LEAP_YEAR_EN
    u_if.leap_year = 1'b1;
    set_month(2);
    cyc("feb_clamp");
    advance_to(28, "leap_prep");
    u_if.day_en = 1'b1;
    cyc("leap_29");
    cyc("leap_roll");
    u_if.leap_year = 1'b0;
    advance_to(28, "noleap_prep");
    u_if.day_en = 1'b1;
    cyc("noleap_roll");
    u_if.leap_year = 1'b1;
    advance_to(29, "leap_fall_prep");
    u_if.leap_year = 1'b0;
    cyc("leap_fall");
`endif

    // Randomized soak over all control inputs and month codes
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) begin
        if ($urandom_range(7) == 0) begin
          u_if.month_tens = 2'($urandom_range(3));
          u_if.month_ones = 4'($urandom_range(15));
        end else begin
          set_month($urandom_range(12, 1));
        end
      end
`ifdef DAY_COUNTER_LEAP_YEAR_EN
      if ($urandom_range(7) == 0) u_if.leap_year = ~u_if.leap_year;
`endif
      if ($urandom_range(15) == 0) u_if.set_mode = ~u_if.set_mode;
      u_if.day_en = 1'($urandom_range(1));
      u_if.incr   = 1'($urandom_range(1));
      u_if.dcr    = 1'($urandom_range(1));
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
